keypad_word_buffer: RTL and testbench
=====================================

Name: keypad_word_buffer

Overview:
Parametrised successor to the keypad word-length counter.
- Runs on the system clock and takes per-key strobes; keypad presses are no longer used as a clock.
- Counts the word length and also stores each key symbol of the word.
- Supports backspace and configurable overflow handling.
- Hands committed words to the downstream matcher through a valid/ready port. A new word can be typed while the previous one is still awaiting acceptance.

Parameters:
MAX_LEN, 7, maximum symbols per word (>=1)
SYM_W, 4, bits per key symbol
OVF_MODE, 0, 0 = saturate (drop digit at full); 1 = restart (discard buffer, digit becomes symbol 0)
CNT_W (localparam), $clog2(MAX_LEN+1), width of length fields

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
key_valid  in  1  one-cycle strobe, one key event this cycle
key_code  in  SYM_W  symbol for a digit event
key_star  in  1  qualifies key_valid as commit (star key)
key_back  in  1  qualifies key_valid as backspace
clear  in  1  synchronous flush of fill buffer
len  out  CNT_W  symbols currently in fill buffer
full  out  1  len == MAX_LEN
overflow  out  1  sticky: a digit arrived while full
word_valid  out  1  committed word available
word_ready  in  1  downstream accepts word when word_valid & word_ready
word_data  out  MAX_LEN*SYM_W  symbol i at [i*SYM_W +: SYM_W]; unused slots zero
word_len  out  CNT_W  length of committed word

Behaviour:
- Reset (reset=0): len=0, overflow=0, word_valid=0, word_data=0, word_len=0, fill buffer zero. Takes effect mid-operation without waiting for clk. Release is synchronous to the next edge.
- Event decode applies only when key_valid=1. Priority is star > back > digit; exactly one event acts per cycle.
- clear=1 overrides any key event that cycle: fill buffer zeroed, len=0, overflow=0. The output side (word_valid/word_data/word_len) is unaffected.
- Digit, len<MAX_LEN: slot[len] <= key_code, len <= len+1 (visible next cycle).
- Digit, len==MAX_LEN:
  - OVF_MODE=0: buffer unchanged, overflow <= 1.
  - OVF_MODE=1: buffer zeroed except slot[0] <= key_code, len <= 1, overflow <= 1.
- Backspace, len>0: slot[len-1] <= 0, len <= len-1.
- Backspace, len==0: no-op.
- Star, len==0: no-op; empty words are never committed.
- Star, len>0, with the output register free: copy fill buffer to word_data, word_len <= len, word_valid <= 1, fill buffer zeroed, len <= 0, overflow <= 0. word_valid rises the cycle after the star strobe. Latency is one cycle.
- Output register free means word_valid==0, or word_valid & word_ready in the same cycle (handover and reload in one edge; word_valid stays 1).
- Star, len>0, output busy (word_valid=1, word_ready=0): star ignored. Fill buffer and len are retained, and the user may press star again.
- Handshake:
  - While word_valid=1 and not accepted, word_data/word_len hold stable.
  - On acceptance with no simultaneous commit, word_valid drops next cycle; word_data/word_len may hold their last value.
  - word_ready while word_valid=0 has no effect.
- Digits and backspace continue to fill the buffer while the output is busy (double buffering).
- Output control FSM:
  - EMPTY (word_valid=0) -> FULL on commit.
  - FULL -> EMPTY on accept without commit.
  - FULL -> FULL on accept with commit, or while waiting.
- len never exceeds MAX_LEN; full is combinational from len.

Test Plan:
- Reset low mid-word: with len=3 and word_valid=1, drive reset=0 between clock edges -> len=0, word_valid=0, overflow=0 immediately.
- Basic word: digits 1,2,3 then star, word_ready=1 -> one cycle after star, word_valid=1, word_len=3, word_data low 12 bits = 0x321. Accepted that cycle, so word_valid=0 on the following cycle and len=0.
- Backspace and edge cases: digits 5,6, back, back, back, star -> len steps 1,2,1,0,0; no word_valid (empty commit ignored).
- Full at MAX_LEN=7, OVF_MODE=0: 8 digits 0..7 -> len=7, full=1, overflow=1, slot6=6; star commits word_len=7 and clears overflow.
- Full with OVF_MODE=1: 8 digits 0..7 -> len=1, slot0=7, overflow=1.
- Backpressure: commit word A (len 2) with word_ready=0, type 3 digits, star -> word_valid stays 1 with A stable and len=3 retained. Raise word_ready together with a second star -> next cycle word_valid=1, word_len=3 (word B), len=0.
- Collision: key_valid with key_star=1 and key_back=1 at len=2 -> commit occurs, no backspace. clear=1 with a star event in the same cycle -> no commit, len=0.

Source files
------------

// File: rtl/keypad_word_buffer_if.sv
// rtl/keypad_word_buffer_if.sv - committed-word valid/ready handshake between buffer and matcher
interface keypad_word_buffer_if #(
  parameter int MAX_LEN = 7,
  parameter int SYM_W   = 4
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic                     word_valid;
  logic                     word_ready;
  logic [MAX_LEN*SYM_W-1:0] word_data;
  logic [CNT_W-1:0]         word_len;

  modport master (output word_valid, output word_data, output word_len, input word_ready);
  modport slave  (input word_valid, input word_data, input word_len, output word_ready);
endinterface

// File: rtl/keypad_word_buffer.sv
// rtl/keypad_word_buffer.sv - keypad symbol fill buffer with double-buffered word output
module keypad_word_buffer #(
  parameter int MAX_LEN  = 7,
  parameter int SYM_W    = 4,
  parameter int OVF_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key_valid,
  input  logic [SYM_W-1:0]     key_code,
  input  logic                 key_star,
  input  logic                 key_back,
  input  logic                 clear,
  output logic [$clog2(MAX_LEN+1)-1:0] len,
  output logic                 full,
  output logic                 overflow,
  keypad_word_buffer_if.master word_if
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int BUF_W = MAX_LEN * SYM_W;
  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             state_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [BUF_W-1:0]   data_q;
  logic [CNT_W-1:0]   wlen_q;

  logic ev_star, ev_back, ev_digit, out_free, commit;

  assign ev_star  = key_valid & key_star;
  assign ev_back  = key_valid & ~key_star & key_back;
  assign ev_digit = key_valid & ~key_star & ~key_back;
  // Output slot is free if empty, or being handed over on this very edge
  assign out_free = (state_q == S_EMPTY) | word_if.word_ready;
  assign commit   = ~clear & ev_star & (len_q != '0) & out_free;

  always_comb begin
    buf_d = buf_q;
    len_d = len_q;
    ovf_d = ovf_q;
    if (clear || commit) begin
      buf_d = '0;
      len_d = '0;
      ovf_d = 1'b0;
    end else if (ev_back) begin
      if (len_q != '0) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (CNT_W'(i + 1) == len_q) buf_d[i*SYM_W +: SYM_W] = '0;
        len_d = len_q - ONE_C;
      end
    end else if (ev_digit) begin
      if (len_q != MAX_LEN_C) begin
        for (int i = 0; i < MAX_LEN; i++)
          if (CNT_W'(i) == len_q) buf_d[i*SYM_W +: SYM_W] = key_code;
        len_d = len_q + ONE_C;
      end else begin
        ovf_d = 1'b1;
        if (OVF_MODE == 1) begin
          buf_d = '0;
          buf_d[SYM_W-1:0] = key_code;
          len_d = ONE_C;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      buf_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      wlen_q  <= '0;
    end else begin
      buf_q <= buf_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
      case (state_q)
        S_EMPTY: begin
          if (commit) begin
            state_q <= S_FULL;
            data_q  <= buf_q;
            wlen_q  <= len_q;
          end
        end
        S_FULL: begin
          if (commit) begin
            data_q <= buf_q;
            wlen_q <= len_q;
          end else if (word_if.word_ready) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  assign len                = len_q;
  assign full               = (len_q == MAX_LEN_C);
  assign overflow           = ovf_q;
  assign word_if.word_valid = (state_q == S_FULL);
  assign word_if.word_data  = data_q;
  assign word_if.word_len   = wlen_q;
endmodule

// File: tb/tb_keypad_word_buffer.sv
// tb/tb_keypad_word_buffer.sv - directed vector bench for keypad_word_buffer
module tb_keypad_word_buffer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic key_valid = 1'b0;
  logic [3:0] key_code = '0;
  logic key_star = 1'b0;
  logic key_back = 1'b0;
  logic clear = 1'b0;
  logic [2:0] len0, len1;
  logic full0, full1, ovf0, ovf1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  keypad_word_buffer_if #(.MAX_LEN(7), .SYM_W(4)) if0 ();
  keypad_word_buffer_if #(.MAX_LEN(7), .SYM_W(4)) if1 ();

  keypad_word_buffer #(.MAX_LEN(7), .SYM_W(4), .OVF_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_star(key_star), .key_back(key_back), .clear(clear),
    .len(len0), .full(full0), .overflow(ovf0), .word_if(if0.master)
  );

  keypad_word_buffer #(.MAX_LEN(7), .SYM_W(4), .OVF_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .key_star(key_star), .key_back(key_back), .clear(clear),
    .len(len1), .full(full1), .overflow(ovf1), .word_if(if1.master)
  );

  typedef struct {
    logic        kv;
    logic [3:0]  code;
    logic        star;
    logic        back;
    logic        clr;
    logic        rdy;
    logic [2:0]  len;
    logic        full;
    logic        ovf;
    logic        wv;
    logic        chkw;
    logic [2:0]  wlen;
    logic [27:0] wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic kv, input logic [3:0] code, input logic star, input logic back,
                     input logic clr, input logic rdy, input logic [2:0] l, input logic f,
                     input logic o, input logic wv, input logic cw, input logic [2:0] wl,
                     input logic [27:0] wd);
    vec_t v;
    v = '{kv, code, star, back, clr, rdy, l, f, o, wv, cw, wl, wd};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ready(input logic r);
    if0.word_ready = r;
    if1.word_ready = r;
  endtask

  task automatic drive(input logic kv, input logic [3:0] code, input logic star,
                       input logic back, input logic clr);
    key_valid = kv;
    key_code  = code;
    key_star  = star;
    key_back  = back;
    clear     = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_ready(1'b0);
    // basic word, accepted the cycle it appears
    add(1,4'h1,0,0,0,1, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h2,0,0,0,1, 3'd2,0,0,0, 0,3'd0,28'h0);
    add(1,4'h3,0,0,0,1, 3'd3,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,1,0,0,1, 3'd0,0,0,1, 1,3'd3,28'h321);
    add(0,4'h0,0,0,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    // backspace edges and empty commit
    add(1,4'h5,0,0,0,1, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h6,0,0,0,1, 3'd2,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,0,1,0,1, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,0,1,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,0,1,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,1,0,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    // fill to MAX_LEN and overflow (saturate)
    add(1,4'h0,0,0,0,1, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h1,0,0,0,1, 3'd2,0,0,0, 0,3'd0,28'h0);
    add(1,4'h2,0,0,0,1, 3'd3,0,0,0, 0,3'd0,28'h0);
    add(1,4'h3,0,0,0,1, 3'd4,0,0,0, 0,3'd0,28'h0);
    add(1,4'h4,0,0,0,1, 3'd5,0,0,0, 0,3'd0,28'h0);
    add(1,4'h5,0,0,0,1, 3'd6,0,0,0, 0,3'd0,28'h0);
    add(1,4'h6,0,0,0,1, 3'd7,1,0,0, 0,3'd0,28'h0);
    add(1,4'h7,0,0,0,1, 3'd7,1,1,0, 0,3'd0,28'h0);
    add(1,4'h0,1,0,0,0, 3'd0,0,0,1, 1,3'd7,28'h6543210);
    // backpressure: type word B while A waits, retried star on accept
    add(0,4'h0,0,0,0,0, 3'd0,0,0,1, 1,3'd7,28'h6543210);
    add(1,4'h9,0,0,0,0, 3'd1,0,0,1, 1,3'd7,28'h6543210);
    add(1,4'h8,0,0,0,0, 3'd2,0,0,1, 1,3'd7,28'h6543210);
    add(1,4'h7,0,0,0,0, 3'd3,0,0,1, 1,3'd7,28'h6543210);
    add(1,4'h0,1,0,0,0, 3'd3,0,0,1, 1,3'd7,28'h6543210);
    add(1,4'h0,1,0,0,1, 3'd0,0,0,1, 1,3'd3,28'h789);
    add(0,4'h0,0,0,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    // star beats back; clear beats star
    add(1,4'h1,0,0,0,0, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h2,0,0,0,0, 3'd2,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,1,1,0,1, 3'd0,0,0,1, 1,3'd2,28'h21);
    add(0,4'h0,0,0,0,1, 3'd0,0,0,0, 0,3'd0,28'h0);
    add(1,4'h4,0,0,0,0, 3'd1,0,0,0, 0,3'd0,28'h0);
    add(1,4'h0,1,0,1,0, 3'd0,0,0,0, 0,3'd0,28'h0);

    // reset state
    #12;
    chk("rst_len", 32'(len0), 32'd0);
    chk("rst_valid", 32'(if0.word_valid), 32'd0);
    chk("rst_wdata", 32'(if0.word_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].kv, vecs[i].code, vecs[i].star, vecs[i].back, vecs[i].clr);
      set_ready(vecs[i].rdy);
      step();
      chk($sformatf("v%0d_len", i), 32'(len0), 32'(vecs[i].len));
      chk($sformatf("v%0d_full", i), 32'(full0), 32'(vecs[i].full));
      chk($sformatf("v%0d_ovf", i), 32'(ovf0), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_wvalid", i), 32'(if0.word_valid), 32'(vecs[i].wv));
      if (vecs[i].chkw) begin
        chk($sformatf("v%0d_wlen", i), 32'(if0.word_len), 32'(vecs[i].wlen));
        chk($sformatf("v%0d_wdata", i), 32'(if0.word_data), 32'(vecs[i].wdata));
      end
    end

    // asynchronous reset between edges with a pending word and partial fill
    set_ready(1'b0);
    drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'h5, 1'b0, 1'b0, 1'b0); step();
    chk("pre_rst_len", 32'(len0), 32'd3);
    chk("pre_rst_valid", 32'(if0.word_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_len", 32'(len0), 32'd0);
    chk("async_rst_valid", 32'(if0.word_valid), 32'd0);
    chk("async_rst_ovf", 32'(ovf0), 32'd0);
    chk("async_rst_wlen", 32'(if0.word_len), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // restart-mode overflow against saturate-mode on the same stimulus
    set_ready(1'b1);
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'(k), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("rst_mode_len", 32'(len1), 32'd1);
    chk("rst_mode_ovf", 32'(ovf1), 32'd1);
    chk("rst_mode_full", 32'(full1), 32'd0);
    chk("sat_mode_len", 32'(len0), 32'd7);
    chk("sat_mode_ovf", 32'(ovf0), 32'd1);
    drive(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
    chk("rst_mode_wlen", 32'(if1.word_len), 32'd1);
    chk("rst_mode_slot0", 32'(if1.word_data), 32'h7);
    chk("rst_mode_ovf_clr", 32'(ovf1), 32'd0);
    chk("sat_mode_wdata", 32'(if0.word_data), 32'h6543210);
    chk("sat_mode_wlen", 32'(if0.word_len), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
